// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one data-memory port between the MEM stages of NUM_CORES pipelines.
//   Requests are granted round-robin. Exactly one memory transaction is in
//   flight at a time. Every requesting core is stalled until its own
//   completion pulse.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   core_req/we      per-core request and store flag; a request is held until its rvalid
//   core_addr/wdata  per-core address and store data, core i at [i*W +: W]
//   core_stall       combinational stall back to each pipeline
//   core_rvalid      one-cycle completion pulse to the served core
//   core_rdata       load data broadcast to all cores, held between pulses
//   mem_*            single-outstanding request/ready, rvalid/rdata memory port
module dmem_port_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_stall,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IdxW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [NUM_CORES-1:0]   core_rvalid_q, core_rvalid_d;
  logic [DATA_W-1:0]      core_rdata_q, core_rdata_d;

  // Unpack the flat per-core buses so the granted core can be selected by index.
  logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
  logic [DATA_W-1:0] wdata_arr [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign addr_arr[i]  = core_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = core_wdata[i*DATA_W +: DATA_W];
  end

  // The core receiving its pulse still holds req for that cycle. Masking it
  // keeps a completed request from being granted twice.
  logic [NUM_CORES-1:0] req_elig;
  logic                 sel_valid;
  logic [IdxW-1:0]      sel_idx;

  assign req_elig = core_req & ~core_rvalid_q;

  // First eligible requester at or above rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin : rr_search
    int unsigned pos;
    pos       = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= NUM_CORES) pos = pos - NUM_CORES;
      if (!sel_valid && req_elig[IdxW'(pos)]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(pos);
      end
    end
  end

  always_comb begin : next_state
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    core_rvalid_d = '0;
    core_rdata_d  = core_rdata_q;
    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          grant_d     = sel_idx;
          mem_addr_d  = addr_arr[sel_idx];
          mem_wdata_d = wdata_arr[sel_idx];
          mem_we_d    = core_we[sel_idx];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (mem_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          core_rdata_d           = mem_rdata;
          core_rvalid_d[grant_q] = 1'b1;
          rr_ptr_d               = (grant_q == IdxW'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
          state_d                = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      core_rvalid_q <= '0;
      core_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      core_rvalid_q <= core_rvalid_d;
      core_rdata_q  <= core_rdata_d;
    end
  end

  // mem_req decodes straight from state, so reset drops it asynchronously.
  assign mem_req     = (state_q == StIssue);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign core_stall  = core_req & ~core_rvalid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed scenarios followed by a randomized phase in which the bench acts
//   as the cores and the memory. A round-robin reference predicts grants,
//   and a small memory array predicts load data.
module tb_dmem_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  core_req = '0;
  logic [N-1:0]  core_we = '0;
  logic [N*AW-1:0] core_addr = '0;
  logic [N*DW-1:0] core_wdata = '0;
  logic [N-1:0]  core_stall;
  logic [N-1:0]  core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state for the randomized phase.
  int unsigned   rr;
  int            txn_core;
  int            g;
  int            pidx;
  int            cd;
  int            ntx;
  bit            in_txn;
  bit            acc_pend;
  bit            waiting;
  bit            rv_driven;
  logic [N-1:0]  prev_req;
  logic [N-1:0]  prev_rv;
  logic [N-1:0]  exp_rv;
  logic [N-1:0]  cand;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] mem_arr [16];

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .NUM_CORES(N),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req[i]             = req;
    core_we[i]              = we;
    core_addr[i*AW +: AW]   = a;
    core_wdata[i*DW +: DW]  = d;
  endtask

  task automatic new_req(input int i);
    set_core(i, 1'b1, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom), 2'b00}, $urandom);
  endtask

  // Zero-wait transaction; call in the cycle the arbiter samples requests.
  // Returns in the pulse cycle of core c.
  task automatic serve(input int c, input logic [DW-1:0] d, input string tag);
    logic [N-1:0] bit_c;
    bit_c      = N'(1) << c;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    step();
    chk({tag, "_req"}, mem_req, 1'b1);
    chk({tag, "_addr"}, mem_addr, core_addr[c*AW +: AW]);
    chk({tag, "_we"}, mem_we, core_we[c]);
    chk({tag, "_wdata"}, mem_wdata, core_wdata[c*DW +: DW]);
    chk({tag, "_stall1"}, core_stall, core_req);
    step();
    chk({tag, "_wait"}, mem_req, 1'b0);
    chk({tag, "_norv"}, core_rvalid, '0);
    chk({tag, "_stall2"}, core_stall, core_req);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    step();
    chk({tag, "_rvalid"}, core_rvalid, bit_c);
    chk({tag, "_rdata"}, core_rdata, d);
    chk({tag, "_stall3"}, core_stall, core_req & ~bit_c);
    mem_rvalid = 1'b0;
    mem_rdata  = ~d;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rvalid", core_rvalid, '0);
    chk("rst_rdata", core_rdata, '0);
    core_req[2] = 1'b1;
    #1 chk("rst_stall_follows_req", core_stall, 4'b0100);
    core_req = '0;
    rst_n = 1'b1;

    // Single load from core 0
    set_core(0, 1'b1, 1'b0, 32'h100, 32'h0);
    #1 chk("ld_stall0", core_stall, 4'b0001);
    serve(0, 32'hDEADBEEF, "ld");
    set_core(0, 1'b0, 1'b0, 32'h100, 32'h0);
    step();
    chk("ld_rv_clear", core_rvalid, '0);
    chk("ld_rdata_hold", core_rdata, 32'hDEADBEEF);

    // Store from core 1 with three ready wait states
    set_core(1, 1'b1, 1'b1, 32'h200, 32'h12345678);
    mem_ready = 1'b0;
    #1 chk("st_stall0", core_stall, 4'b0010);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("st_req", mem_req, 1'b1);
      chk("st_addr", mem_addr, 32'h200);
      chk("st_wdata", mem_wdata, 32'h12345678);
      chk("st_we", mem_we, 1'b1);
      chk("st_stall", core_stall, 4'b0010);
      if (j == 3) mem_ready = 1'b1;
    end
    step();
    chk("st_wait", mem_req, 1'b0);
    chk("st_stall_wait", core_stall, 4'b0010);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    step();
    chk("st_rvalid", core_rvalid, 4'b0010);
    chk("st_stall_rel", core_stall, 4'b0000);
    mem_rvalid = 1'b0;
    set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Simultaneous requests from reset: strict alternation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_core(0, 1'b1, 1'b0, 32'h300, 32'h0);
    set_core(1, 1'b1, 1'b0, 32'h304, 32'h0);
    serve(0, 32'hA0A0A0A0, "alt0");
    serve(1, 32'hA1A1A1A1, "alt1");
    serve(0, 32'hA2A2A2A2, "alt2");
    serve(1, 32'hA3A3A3A3, "alt3");

    // Cores 1 and 3 with rr_ptr at 2: core 3 first, then core 1
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(1, 1'b1, 1'b1, 32'h310, 32'h11110001);
    set_core(3, 1'b1, 1'b1, 32'h3C0, 32'hCAFE0003);
    serve(3, 32'h33333333, "rr3");
    set_core(3, 1'b0, 1'b0, 32'h0, 32'h0);
    serve(1, 32'h11111111, "rr1");
    set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Flush: core 0 drops its request while the load is in flight
    set_core(0, 1'b1, 1'b0, 32'h400, 32'h0);
    mem_ready = 1'b1;
    step();
    chk("fl_issue", mem_req, 1'b1);
    step();
    chk("fl_wait", mem_req, 1'b0);
    mem_ready = 1'b0;
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("fl_stall", core_stall, 4'b0000);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555AAAA;
    step();
    chk("fl_rvalid", core_rvalid, 4'b0001);
    chk("fl_rdata", core_rdata, 32'h5555AAAA);
    mem_rvalid = 1'b0;
    step();
    chk("fl_idle", mem_req, 1'b0);
    chk("fl_rv_clear", core_rvalid, '0);
    step();
    chk("fl_nogrant", mem_req, 1'b0);

    // Reset during ISSUE
    set_core(2, 1'b1, 1'b0, 32'h500, 32'h0);
    mem_ready = 1'b0;
    step();
    chk("ri_issue", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ri_async_req", mem_req, 1'b0);
    chk("ri_async_addr", mem_addr, '0);
    chk("ri_stall", core_stall, 4'b0100);
    step();
    set_core(2, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(0, 1'b1, 1'b0, 32'h600, 32'h0);
    set_core(1, 1'b1, 1'b0, 32'h604, 32'h0);
    rst_n = 1'b1;
    serve(0, 32'h600D0000, "ri_post");
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic against the reference model
    rst_n = 1'b0;
    step();
    for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
    rr = 0; in_txn = 0; acc_pend = 0; waiting = 0; rv_driven = 0; ntx = 0;
    txn_core = 0; cd = 0;
    prev_req = '0; prev_rv = '0; exp_rv = '0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_data = '0;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      exp_rv = rv_driven ? (N'(1) << txn_core) : '0;
      chk("r_rvalid", core_rvalid, exp_rv);
      chk("r_stall", core_stall, core_req & ~exp_rv);
      if (rv_driven) begin
        chk("r_rdata", core_rdata, exp_data);
        rr     = (32'(txn_core) + 1) % N;
        in_txn = 0;
        ntx++;
      end
      if (acc_pend) begin
        acc_pend = 0;
        waiting  = 1;
        cd       = int'($urandom_range(0, 2));
        chk("r_accepted", mem_req, 1'b0);
      end else if (waiting) begin
        chk("r_wait_noreq", mem_req, 1'b0);
      end else if (mem_req && !in_txn) begin
        cand = prev_req & ~prev_rv;
        g    = -1;
        for (int k = 0; k < int'(N); k++) begin
          pidx = (int'(rr) + k) % int'(N);
          if (g < 0 && cand[pidx]) g = pidx;
        end
        chk("r_grant_any", (g >= 0), 1'b1);
        if (g < 0) g = 0;
        txn_core  = g;
        in_txn    = 1;
        exp_we    = core_we[g];
        exp_addr  = core_addr[g*AW +: AW];
        exp_wdata = core_wdata[g*DW +: DW];
        chk("r_addr", mem_addr, exp_addr);
        chk("r_we", mem_we, exp_we);
        chk("r_wdata", mem_wdata, exp_wdata);
      end else if (mem_req) begin
        chk("r_hold_addr", mem_addr, exp_addr);
        chk("r_hold_wdata", mem_wdata, exp_wdata);
      end

      // Memory side
      mem_rvalid = 1'b0;
      rv_driven  = 0;
      mem_ready  = 1'b0;
      mem_rdata  = $urandom;
      if (waiting) begin
        if (cd == 0) begin
          waiting = 0;
          if (exp_we) begin
            mem_arr[exp_addr[5:2]] = exp_wdata;
            exp_data = $urandom;
          end else begin
            exp_data = mem_arr[exp_addr[5:2]];
          end
          mem_rdata  = exp_data;
          mem_rvalid = 1'b1;
          rv_driven  = 1;
        end else begin
          cd--;
        end
      end else if (mem_req) begin
        mem_ready = ($urandom_range(0, 2) != 0);
        acc_pend  = mem_ready;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end

      // Core side: hold until served, then drop or issue a fresh request
      for (int i = 0; i < int'(N); i++) begin
        if (core_req[i] && exp_rv[i]) begin
          if ($urandom_range(0, 1) == 0) core_req[i] = 1'b0;
          else new_req(i);
        end else if (!core_req[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
      prev_req = core_req;
      prev_rv  = exp_rv;
    end
    chk("r_progress", (ntx > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
